// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the IF/ID
// pipeline register that hands one fetched instruction per clock to decode.
module if_stage #(
  parameter int unsigned  n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_target,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic [n-1:0] instr_in,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4_out,
  output logic [n-1:0] instr_out,
  output logic         valid_out,
  output logic [31:0]  fetch_count
);

  localparam logic [n-1:0] Four = n'(4);

  logic [n-1:0] pc_plus4;
  logic [n-1:0] jump_aligned;
  logic [n-1:0] branch_aligned;
  logic         redirect;

  logic [n-1:0] pc_d;
  logic [n-1:0] pc_plus4_d;
  logic [n-1:0] instr_d;
  logic         valid_d;
  logic [31:0]  fetch_count_d;

  // Carry out of the top bit is dropped so the address space wraps to zero.
  assign pc_plus4       = pc + Four;
  assign jump_aligned   = {jump_target[n-1:2], 2'b00};
  assign branch_aligned = {branch_target[n-1:2], 2'b00};
  assign redirect       = jump | branch_taken;

  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = jump_aligned;
    end else if (branch_taken) begin
      pc_d = branch_aligned;
    end else if (stall) begin
      pc_d = pc;
    end
  end

  // A redirect squashes the instruction fetched down the wrong path.
  always_comb begin
    pc_plus4_d    = pc_plus4_out;
    instr_d       = instr_out;
    valid_d       = valid_out;
    fetch_count_d = fetch_count;
    if (redirect || flush) begin
      pc_plus4_d = '0;
      instr_d    = '0;
      valid_d    = 1'b0;
    end else if (!stall) begin
      pc_plus4_d    = pc_plus4;
      instr_d       = instr_in;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      pc_plus4_out <= '0;
      instr_out    <= '0;
      valid_out    <= 1'b0;
      fetch_count  <= '0;
    end else begin
      pc           <= pc_d;
      pc_plus4_out <= pc_plus4_d;
      instr_out    <= instr_d;
      valid_out    <= valid_d;
      fetch_count  <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a behavioural fetch model is compared against the DUT on
// every negative clock edge, and hand-computed scenario checks pin the model itself.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  // Reference state
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_p4 = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_fetched;
  logic [31:0] m_seq;

  if_stage #(
    .n       (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instr_in     (instr_in),
    .pc           (pc),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .fetch_count  (fetch_count)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign instr_in = imem(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fetch consumes the word at the current PC; redirects and flushes squash it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = '0; m_p4 = '0; m_valid = 1'b0; m_cnt = '0;
    end else begin
      m_fetched = imem(m_pc);
      m_seq     = m_pc + 32'd4;
      if (jump) m_pc = jump_target & ~32'h3;
      else if (branch_taken) m_pc = branch_target & ~32'h3;
      else if (!stall) m_pc = m_seq;
      if (jump || branch_taken || flush) begin
        m_instr = '0; m_p4 = '0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = m_fetched; m_p4 = m_seq; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_instr", instr_out, m_instr);
    chk("model_pc_plus4", pc_plus4_out, m_p4);
    chk("model_valid", {31'b0, valid_out}, {31'b0, m_valid});
    chk("model_count", fetch_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    #25;
    chk("reset_pc", pc, 32'h0);
    chk("reset_instr", instr_out, 32'h0);
    chk("reset_valid", {31'b0, valid_out}, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    rst = 1'b0;

    tick();
    chk("seq_pc", pc, 32'h4);
    chk("seq_instr", instr_out, 32'h2008_0005);
    chk("seq_pc_plus4", pc_plus4_out, 32'h4);
    chk("seq_valid", {31'b0, valid_out}, 32'h1);
    chk("seq_count", fetch_count, 32'h1);

    tick();
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_pc", pc, 32'h8);
    chk("stall_instr", instr_out, imem(32'h4));
    chk("stall_pc_plus4", pc_plus4_out, 32'h8);
    chk("stall_count", fetch_count, 32'h2);
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 32'hC);
    chk("unstall_count", fetch_count, 32'h3);

    tick();
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("branch_pc", pc, 32'h40);
    chk("branch_valid", {31'b0, valid_out}, 32'h0);
    chk("branch_instr", instr_out, 32'h0);
    chk("branch_count", fetch_count, 32'h4);
    branch_taken = 1'b0;
    tick();
    chk("after_branch_instr", instr_out, imem(32'h40));
    chk("after_branch_pc", pc, 32'h44);

    jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1;
    tick();
    chk("prio_pc", pc, 32'h100);
    chk("prio_valid", {31'b0, valid_out}, 32'h0);
    branch_taken = 1'b0; stall = 1'b0; jump_target = 32'h103;
    tick();
    chk("align_pc", pc, 32'h100);

    jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_jump_pc", pc, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc_plus4", pc_plus4_out, 32'h0);
    chk("wrap_valid", {31'b0, valid_out}, 32'h1);
    chk("wrap_instr", instr_out, imem(32'hFFFF_FFFC));

    repeat (5) tick();
    chk("pre_reset_pc", pc, 32'h14);
    #4 rst = 1'b1;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instr", instr_out, 32'h0);
    chk("midrst_pc_plus4", pc_plus4_out, 32'h0);
    chk("midrst_valid", {31'b0, valid_out}, 32'h0);
    chk("midrst_count", fetch_count, 32'h0);
    #1 rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      tick();
      r = $urandom;
      stall         = (r[2:0] == 3'd0);
      flush         = (r[7:4] == 4'd0);
      branch_taken  = (r[11:8] == 4'd0);
      jump          = (r[15:12] == 4'd0);
      branch_target = $urandom;
      jump_target   = $urandom;
      if (r[23:18] == 6'd0) begin
        #4 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    tick();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning datapath and address width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 The block SHALL have port stall  input  1  meaning hold the PC and IF/ID register (hazard from decode).
REQ-006 The block SHALL have port flush  input  1  meaning invalidate the IF/ID register content.
REQ-007 The block SHALL have port branch_taken  input  1  meaning redirect the PC to branch_target.
REQ-008 The block SHALL have port branch_target  input  n  meaning the branch destination address.
REQ-009 The block SHALL have port jump  input  1  meaning redirect the PC to jump_target.
REQ-010 The block SHALL have port jump_target  input  n  meaning the jump destination address.
REQ-011 The block SHALL have port instr_in  input  n  meaning the instruction word read combinationally from imem at address pc.
REQ-012 The block SHALL have port pc  output  n  meaning the current fetch address, driven to imem.
REQ-013 The block SHALL have port pc_plus4_out  output  n  meaning the registered PC+4 of the instruction held in IF/ID.
REQ-014 The block SHALL have port instr_out  output  n  meaning the registered instruction held in IF/ID.
REQ-015 The block SHALL have port valid_out  output  1  meaning instr_out/pc_plus4_out hold a live instruction.
REQ-016 The block SHALL have port fetch_count  output  32  meaning the number of instructions accepted into IF/ID.

Function
REQ-017 The PC+4 sum SHALL be computed modulo 2^n; pc = 2^n-4 SHALL yield 0 with no carry out.
REQ-018 The next-PC priority SHALL be: jump, then branch_taken, then stall (hold), then sequential pc+4.
REQ-019 A redirect (jump or branch_taken) SHALL update the PC even while stall is high.
REQ-020 Redirect targets SHALL be word-aligned by forcing bits [1:0] to 0 before loading the PC.
REQ-021 In an ordinary cycle (no stall, flush or redirect), IF/ID SHALL capture instr_in, pc+4 and valid_out=1 on the edge.
REQ-022 While stall is high and there is no flush or redirect, IF/ID SHALL hold all its values unchanged.
REQ-023 A flush, jump or branch_taken cycle SHALL load IF/ID with instr_out=0 (NOP), pc_plus4_out=0 and valid_out=0; the fetched instruction is discarded.
REQ-024 Flush SHALL take priority over stall for IF/ID; flush alone SHALL NOT change the PC sequencing (PC still advances unless stalled).
REQ-025 fetch_count SHALL increment by 1 on each edge where IF/ID captures with valid_out=1, and SHALL wrap from 2^32-1 to 0.
REQ-026 The latency from pc presentation to instr_out SHALL be exactly one clock.

Reset
REQ-027 While rst is high, the block SHALL hold pc=RESET_PC, instr_out=0, pc_plus4_out=0, valid_out=0 and fetch_count=0, asynchronously and independent of clk.
REQ-028 rst asserted mid-operation SHALL override stall, flush and redirect immediately.
REQ-029 The first rising edge after rst deasserts SHALL capture the instruction at RESET_PC and set pc=RESET_PC+4.

Verification
REQ-030 The bench SHALL cover sequential fetch: reset, imem returns 0x20080005 at 0 -> after 1 edge pc=4, instr_out=0x20080005, pc_plus4_out=4, valid_out=1, fetch_count=1.
REQ-031 The bench SHALL cover stall: stall held 3 cycles at pc=8 -> pc stays 8, IF/ID unchanged, fetch_count unchanged; release -> pc=12.
REQ-032 The bench SHALL cover branch: branch_taken=1, branch_target=0x40 at pc=0x10 -> pc=0x40, valid_out=0, instr_out=0; next edge captures instr at 0x40.
REQ-033 The bench SHALL cover simultaneous events: jump=1 (0x100), branch_taken=1 (0x80) and stall=1 in the same cycle -> pc=0x100, valid_out=0; jump_target=0x103 -> pc=0x100.
REQ-034 The bench SHALL cover wrap-around: pc forced to 0xFFFFFFFC by jump -> next sequential pc=0, pc_plus4_out=0 for that instruction.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed between edges after 5 fetches -> outputs zeroed and pc=RESET_PC immediately, fetch_count=0.
